// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the GCD job scheduler: register map, status layout, FSM states.
package gcd_sched_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 16;

   localparam logic [ADDR_W-1:0] OFS_A1     = 16'h0000;
   localparam logic [ADDR_W-1:0] OFS_A2     = 16'h0008;
   localparam logic [ADDR_W-1:0] OFS_RES    = 16'h0010;
   localparam logic [ADDR_W-1:0] OFS_STATUS = 16'h0018;
   localparam logic [ADDR_W-1:0] OFS_CTRL   = 16'h0020;

   localparam int unsigned ST_JOB_FULL  = 0;
   localparam int unsigned ST_JOB_EMPTY = 1;
   localparam int unsigned ST_RES_FULL  = 2;
   localparam int unsigned ST_RES_EMPTY = 3;
   localparam int unsigned ST_BUSY      = 4;
   localparam int unsigned ST_OVERFLOW  = 5;
   localparam int unsigned ST_UNDERFLOW = 6;
   localparam int unsigned ST_TIMEOUT   = 7;
   localparam int unsigned ST_DONE_LSB  = 8;
   localparam int unsigned DONE_CNT_W   = 8;

   localparam int unsigned CTRL_FLUSH = 0;
   localparam int unsigned CTRL_CLEAR = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_STORE
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } job_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Bus-facing scheduler: queues operand pairs, launches them one at a time on the GCD core,
// guards each run with a watchdog, and queues results for the CPU.
module gcd_job_scheduler
   import gcd_sched_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0100,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] saddress,
   input  logic        srd,
   input  logic        swr,
   input  logic [31:0] sdata_in,
   output logic [31:0] sdata_out,
   output logic [31:0] gpio_out,
   output logic        core_start,
   output logic        core_abort,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   input  logic        core_done,
   input  logic [31:0] core_result
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   localparam logic [15:0] ADDR_A1     = BASE_ADDR + OFS_A1;
   localparam logic [15:0] ADDR_A2     = BASE_ADDR + OFS_A2;
   localparam logic [15:0] ADDR_RES    = BASE_ADDR + OFS_RES;
   localparam logic [15:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;
   localparam logic [15:0] ADDR_CTRL   = BASE_ADDR + OFS_CTRL;

   state_e                state_q, state_d;
   logic [TIMEOUT_W-1:0]  wd_q, wd_d;
   logic [31:0]           a1_q, a1_d;
   logic [31:0]           result_q, result_d;
   logic [31:0]           gpio_q, gpio_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [31:0]           core_a_q, core_a_d;
   logic [31:0]           core_b_q, core_b_d;
   logic                  start_q, start_d;
   logic                  abort_q, abort_d;
   logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  tmo_q, tmo_d;

   logic        wr_a1, wr_a2, wr_ctrl, rd_res, rd_status;
   logic        flush, clear_sticky, tmo_set;
   logic        job_pop, res_push;
   job_t        job_wdata, job_head;
   logic        job_full, job_empty, res_full, res_empty;
   logic [CW-1:0] job_cnt, res_cnt;
   logic [31:0] res_head;
   logic [31:0] status_c;

   assign wr_a1        = swr && (saddress == ADDR_A1);
   assign wr_a2        = swr && (saddress == ADDR_A2);
   assign wr_ctrl      = swr && (saddress == ADDR_CTRL);
   assign rd_res       = srd && (saddress == ADDR_RES);
   assign rd_status    = srd && (saddress == ADDR_STATUS);
   assign flush        = wr_ctrl && sdata_in[CTRL_FLUSH];
   assign clear_sticky = wr_ctrl && sdata_in[CTRL_CLEAR];
   assign job_wdata    = '{a: a1_q, b: sdata_in};

   sync_fifo #(.WIDTH($bits(job_t)), .DEPTH(DEPTH)) u_job_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (wr_a2),
      .pop   (job_pop),
      .wdata (job_wdata),
      .rdata (job_head),
      .full  (job_full),
      .empty (job_empty),
      .count (job_cnt)
   );

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (res_push),
      .pop   (rd_res),
      .wdata (result_q),
      .rdata (res_head),
      .full  (res_full),
      .empty (res_empty),
      .count (res_cnt)
   );

   always_comb begin
      status_c               = '0;
      status_c[ST_JOB_FULL]  = (job_cnt == CW'(DEPTH));
      status_c[ST_JOB_EMPTY] = (job_cnt == '0);
      status_c[ST_RES_FULL]  = (res_cnt == CW'(DEPTH));
      status_c[ST_RES_EMPTY] = (res_cnt == '0);
      status_c[ST_BUSY]      = (state_q != S_IDLE);
      status_c[ST_OVERFLOW]  = ovf_q;
      status_c[ST_UNDERFLOW] = udf_q;
      status_c[ST_TIMEOUT]   = tmo_q;
      status_c[ST_DONE_LSB +: DONE_CNT_W] = done_cnt_q;
   end

   // Job sequencing; a flush overrides whatever the state would otherwise do this cycle.
   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      result_d   = result_q;
      gpio_d     = gpio_q;
      core_a_d   = core_a_q;
      core_b_d   = core_b_q;
      done_cnt_d = done_cnt_q;
      start_d    = 1'b0;
      abort_d    = 1'b0;
      job_pop    = 1'b0;
      res_push   = 1'b0;
      tmo_set    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!job_empty) begin
               job_pop = 1'b1;
               if ((job_head.a == '0) || (job_head.b == '0)) begin
                  result_d = job_head.a | job_head.b;
                  state_d  = S_STORE;
               end else begin
                  core_a_d = job_head.a;
                  core_b_d = job_head.b;
                  start_d  = 1'b1;
                  wd_d     = '0;
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (core_done) begin
               result_d = core_result;
               state_d  = S_STORE;
            end else if (wd_q == WD_MAX) begin
               abort_d  = 1'b1;
               result_d = '0;
               tmo_set  = 1'b1;
               state_d  = S_STORE;
            end else begin
               wd_d = wd_q + TIMEOUT_W'(1);
            end
         end
         S_STORE: begin
            if (!res_full || rd_res) begin
               res_push   = 1'b1;
               gpio_d     = result_q;
               done_cnt_d = done_cnt_q + DONE_CNT_W'(1);
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d    = S_IDLE;
         result_d   = result_q;
         gpio_d     = gpio_q;
         core_a_d   = core_a_q;
         core_b_d   = core_b_q;
         done_cnt_d = done_cnt_q;
         start_d    = 1'b0;
         abort_d    = (state_q == S_WAIT);
         job_pop    = 1'b0;
         res_push   = 1'b0;
         tmo_set    = 1'b0;
      end
   end

   // Bus side: operand latch, sticky flags and registered read data.
   always_comb begin
      a1_d  = wr_a1 ? sdata_in : a1_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      tmo_d = tmo_q;
      if (clear_sticky) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
         tmo_d = 1'b0;
      end
      if (wr_a2 && job_full && !job_pop) ovf_d = 1'b1;
      if (rd_res && res_empty)           udf_d = 1'b1;
      if (tmo_set)                       tmo_d = 1'b1;
      rdata_d = '0;
      if (rd_res && !res_empty) rdata_d = res_head;
      else if (rd_status)       rdata_d = status_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wd_q       <= '0;
         a1_q       <= '0;
         result_q   <= '0;
         gpio_q     <= '0;
         rdata_q    <= '0;
         core_a_q   <= '0;
         core_b_q   <= '0;
         start_q    <= 1'b0;
         abort_q    <= 1'b0;
         done_cnt_q <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wd_q       <= wd_d;
         a1_q       <= a1_d;
         result_q   <= result_d;
         gpio_q     <= gpio_d;
         rdata_q    <= rdata_d;
         core_a_q   <= core_a_d;
         core_b_q   <= core_b_d;
         start_q    <= start_d;
         abort_q    <= abort_d;
         done_cnt_q <= done_cnt_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         tmo_q      <= tmo_d;
      end
   end

   assign sdata_out  = rdata_q;
   assign gpio_out   = gpio_q;
   assign core_start = start_q;
   assign core_abort = abort_q;
   assign core_a     = core_a_q;
   assign core_b     = core_b_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler with a behavioural subtractive GCD core model.
module tb_gcd_job_scheduler;

   localparam logic [15:0] BASE   = 16'h0100;
   localparam logic [15:0] R_A1   = 16'h0000;
   localparam logic [15:0] R_A2   = 16'h0008;
   localparam logic [15:0] R_RES  = 16'h0010;
   localparam logic [15:0] R_STAT = 16'h0018;
   localparam logic [15:0] R_CTRL = 16'h0020;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] saddress = '0;
   logic        srd = 1'b0;
   logic        swr = 1'b0;
   logic [31:0] sdata_in = '0;
   logic [31:0] sdata_out, gpio_out, core_a, core_b, core_result;
   logic        core_start, core_abort, core_done;

   logic        m_busy = 1'b0, m_done = 1'b0, stall = 1'b0, force_done = 1'b0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0, force_res = '0;
   int          n_start = 0;
   int          n_chk = 0, n_bad = 0;

   always #5 clk = ~clk;

   gcd_job_scheduler #(.BASE_ADDR(BASE), .DEPTH(4), .TIMEOUT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .saddress    (saddress),
      .srd         (srd),
      .swr         (swr),
      .sdata_in    (sdata_in),
      .sdata_out   (sdata_out),
      .gpio_out    (gpio_out),
      .core_start  (core_start),
      .core_abort  (core_abort),
      .core_a      (core_a),
      .core_b      (core_b),
      .core_done   (core_done),
      .core_result (core_result)
   );

   // Core model: one subtraction per cycle, done pulse when operands match.
   assign core_done   = m_done | force_done;
   assign core_result = force_done ? force_res : m_res;

   always @(posedge clk) begin
      m_done <= 1'b0;
      if (core_start) n_start <= n_start + 1;
      if (reset || core_abort) begin
         m_busy <= 1'b0;
      end else if (core_start) begin
         m_a    <= core_a;
         m_b    <= core_b;
         m_busy <= 1'b1;
      end else if (m_busy && !stall) begin
         if (m_a == m_b) begin
            m_done <= 1'b1;
            m_res  <= m_a;
            m_busy <= 1'b0;
         end else if (m_a > m_b) begin
            m_a <= m_a - m_b;
         end else begin
            m_b <= m_b - m_a;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] ofs, input logic [31:0] d);
      @(negedge clk);
      saddress = BASE + ofs;
      sdata_in = d;
      swr      = 1'b1;
      @(negedge clk);
      swr      = 1'b0;
      saddress = '0;
      sdata_in = '0;
   endtask

   task automatic bus_rd(input logic [15:0] ofs, output logic [31:0] d);
      @(negedge clk);
      saddress = BASE + ofs;
      srd      = 1'b1;
      @(negedge clk);
      srd      = 1'b0;
      saddress = '0;
      d        = sdata_out;
   endtask

   task automatic wait_gpio(input string tag, input logic [31:0] exp, input int max_cyc);
      for (int i = 0; i < max_cyc && gpio_out !== exp; i++) @(negedge clk);
      check_eq(tag, gpio_out, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      stall      = 1'b0;
      force_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          n0, t_start, t_abort;

      // Reset values
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_sdata_out", sdata_out, 32'h0);
      check_eq("rst_gpio", gpio_out, 32'h0);
      check_eq("rst_start_abort", {30'h0, core_start, core_abort}, 32'h0);
      check_eq("rst_core_a", core_a, 32'h0);
      bus_rd(R_STAT, rd);
      check_eq("rst_status", rd, 32'h0000_000A);

      // 12,18: launch two cycles after the A2 write, result 6
      bus_wr(R_A1, 32'd12);
      bus_wr(R_A2, 32'd18);
      check_eq("start_t1", {31'h0, core_start}, 32'h0);
      @(negedge clk);
      check_eq("start_t2", {31'h0, core_start}, 32'h1);
      check_eq("core_a_12", core_a, 32'd12);
      check_eq("core_b_18", core_b, 32'd18);
      wait_gpio("gpio_6", 32'd6, 30);
      bus_rd(R_RES, rd);
      check_eq("res_6", rd, 32'd6);
      bus_rd(R_STAT, rd);
      check_eq("status_after_6", rd, 32'h0000_010A);

      // Zero operands bypass the core
      do_reset();
      n0 = n_start;
      bus_wr(R_A1, 32'd0);
      bus_wr(R_A2, 32'd7);
      wait_gpio("gpio_7", 32'd7, 20);
      check_eq("no_launch_zero", 32'(n_start - n0), 32'd0);
      bus_rd(R_RES, rd);
      check_eq("res_7", rd, 32'd7);
      bus_wr(R_A2, 32'd0);
      repeat (6) @(negedge clk);
      check_eq("gpio_0", gpio_out, 32'd0);
      bus_rd(R_RES, rd);
      check_eq("res_0", rd, 32'd0);
      bus_rd(R_STAT, rd);
      check_eq("status_zero_jobs", rd, 32'h0000_020A);

      // Overflow: 1 launched, 4 queued, 6th write dropped
      do_reset();
      stall = 1'b1;
      bus_wr(R_A1, 32'd5);
      @(negedge clk);
      saddress = BASE + R_A2;
      sdata_in = 32'd10;
      swr      = 1'b1;
      repeat (6) @(negedge clk);
      swr      = 1'b0;
      saddress = '0;
      sdata_in = '0;
      bus_rd(R_STAT, rd);
      check_eq("status_overflow", rd, 32'h0000_0039);
      bus_wr(R_CTRL, 32'h2);
      bus_rd(R_STAT, rd);
      check_eq("status_ovf_cleared", rd, 32'h0000_0019);

      // Watchdog expiry on a core that never finishes
      do_reset();
      bus_wr(R_A1, 32'd0);
      bus_wr(R_A2, 32'd5);
      wait_gpio("gpio_5", 32'd5, 20);
      stall = 1'b1;
      bus_wr(R_A1, 32'd3);
      bus_wr(R_A2, 32'd9);
      t_start = -1;
      t_abort = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (core_start && t_start < 0) t_start = i;
         if (core_abort && t_abort < 0) t_abort = i;
      end
      check_eq("abort_seen", {31'h0, t_abort >= 0 && t_start >= 0}, 32'h1);
      check_eq("abort_delay_ok",
               {31'h0, ((t_abort - t_start) == 15) || ((t_abort - t_start) == 16)}, 32'h1);
      check_eq("gpio_timeout", gpio_out, 32'd0);
      bus_rd(R_RES, rd);
      check_eq("res_5", rd, 32'd5);
      bus_rd(R_RES, rd);
      check_eq("res_timeout", rd, 32'd0);
      bus_rd(R_STAT, rd);
      check_eq("status_timeout", rd, 32'h0000_028A);
      bus_rd(R_RES, rd);
      check_eq("res_underflow_data", rd, 32'd0);
      bus_rd(R_STAT, rd);
      check_eq("status_underflow", rd, 32'h0000_02CA);

      // Result FIFO full: fifth result waits in STORE
      do_reset();
      bus_wr(R_A1, 32'd0);
      for (int j = 1; j <= 5; j++) bus_wr(R_A2, 32'(j));
      repeat (6) @(negedge clk);
      bus_rd(R_STAT, rd);
      check_eq("status_res_full_stall", rd, 32'h0000_0416);
      check_eq("gpio_4", gpio_out, 32'd4);
      bus_rd(16'h0004, rd);
      check_eq("unmapped_rd", rd, 32'd0);
      bus_rd(R_A1, rd);
      check_eq("wo_reg_rd", rd, 32'd0);
      bus_rd(R_RES, rd);
      check_eq("res_1", rd, 32'd1);
      repeat (2) @(negedge clk);
      check_eq("gpio_5_after_pop", gpio_out, 32'd5);
      bus_rd(R_STAT, rd);
      check_eq("status_res_full_idle", rd, 32'h0000_0506);
      bus_rd(R_RES, rd);
      check_eq("res_2", rd, 32'd2);

      // Flush in WAIT with a same-cycle core_done
      do_reset();
      bus_wr(R_A1, 32'd0);
      bus_wr(R_A2, 32'd9);
      wait_gpio("gpio_9", 32'd9, 20);
      stall = 1'b1;
      bus_wr(R_A1, 32'd12);
      bus_wr(R_A2, 32'd18);
      bus_wr(R_A2, 32'd30);
      @(negedge clk);
      saddress   = BASE + R_CTRL;
      sdata_in   = 32'h1;
      swr        = 1'b1;
      force_res  = 32'd77;
      force_done = 1'b1;
      @(negedge clk);
      swr        = 1'b0;
      saddress   = '0;
      sdata_in   = '0;
      force_done = 1'b0;
      check_eq("flush_abort", {31'h0, core_abort}, 32'h1);
      n0 = n_start;
      repeat (4) @(negedge clk);
      check_eq("flush_no_relaunch", 32'(n_start - n0), 32'd0);
      check_eq("flush_gpio_kept", gpio_out, 32'd9);
      bus_rd(R_STAT, rd);
      check_eq("status_after_flush", rd, 32'h0000_010A);

      // A1 persists; reset in WAIT clears all outputs at once
      bus_wr(R_A2, 32'd20);
      @(negedge clk);
      check_eq("a1_persist", core_a, 32'd12);
      check_eq("a2_reuse", core_b, 32'd20);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_gpio", gpio_out, 32'd0);
      check_eq("midrst_core_ab", core_a | core_b, 32'd0);
      check_eq("midrst_pulses", {30'h0, core_start, core_abort}, 32'h0);
      check_eq("midrst_sdata", sdata_out, 32'd0);
      reset = 1'b0;
      bus_rd(R_STAT, rd);
      check_eq("status_after_midrst", rd, 32'h0000_000A);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
